// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: immediate format encoding and the immediate builder.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_fmt_e;

    // src is instruction bits [31:7]; bit 31 is the sign for every format.
    function automatic logic [XLEN-1:0] imm_build(input logic [31:7] src, input imm_fmt_e fmt);
        logic [XLEN-1:0] imm;
        imm = '0;
        unique case (fmt)
            IMM_I: imm = {{20{src[31]}}, src[31:20]};
            IMM_S: imm = {{20{src[31]}}, src[31:25], src[11:7]};
            IMM_B: imm = {{19{src[31]}}, src[31], src[7], src[30:25], src[11:8], 1'b0};
            IMM_J: imm = {{11{src[31]}}, src[31], src[19:12], src[20], src[30:21], 1'b0};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/imm_extend_unit.sv
// RV32I immediate generator with an optional one-cycle output register.
module imm_extend_unit
    import riscv_pkg::*;
#(
    parameter bit REG_OUT = 1'b0,
    parameter int XLEN_P  = XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:7]       src,
    input  logic [1:0]        control,
    output logic [XLEN_P-1:0] extended_src
);

    if (XLEN_P != 32) begin : g_bad_xlen
        $error("imm_extend_unit: only XLEN=32 is supported");
    end

    logic [XLEN_P-1:0] ext_d;

    always_comb begin
        ext_d = imm_build(src, imm_fmt_e'(control));
    end

    if (REG_OUT) begin : g_reg
        logic [XLEN_P-1:0] ext_q;

        // Async clear; no enable, so every edge out of reset reloads.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ext_q <= '0;
            end else begin
                ext_q <= ext_d;
            end
        end

        assign extended_src = ext_q;
    end else begin : g_comb
        // Clock and reset have no role in the pass-through build.
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst_n};
        assign extended_src   = ext_d;
    end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed-vector bench for both the combinational and the registered build.
module tb_imm_extend_unit;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  ctl;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [24:0] src;
    logic [1:0]  control;
    logic [31:0] ext_comb;
    logic [31:0] ext_reg;

    int pass_cnt;
    int total_cnt;

    vec_t vecs[16];

    assign src = instr[31:7];

    imm_extend_unit #(.REG_OUT(1'b0)) u_comb (
        .clk          (clk),
        .rst_n        (rst_n),
        .src          (src),
        .control      (control),
        .extended_src (ext_comb)
    );

    imm_extend_unit #(.REG_OUT(1'b1)) u_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .src          (src),
        .control      (control),
        .extended_src (ext_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;

        vecs[0]  = '{32'h0060_0093, 2'b00, 32'h0000_0006, "I_pos6"};
        vecs[1]  = '{32'hFFA0_0093, 2'b00, 32'hFFFF_FFFA, "I_neg6"};
        vecs[2]  = '{32'h0020_A323, 2'b01, 32'h0000_0006, "S_pos6"};
        vecs[3]  = '{32'hFE20_AD23, 2'b01, 32'hFFFF_FFFA, "S_neg6"};
        vecs[4]  = '{32'h0020_8263, 2'b10, 32'h0000_0004, "B_pos4"};
        vecs[5]  = '{32'hFE20_8EE3, 2'b10, 32'hFFFF_FFFC, "B_neg4"};
        vecs[6]  = '{32'h01A0_04EF, 2'b11, 32'h0000_001A, "J_pos26"};
        vecs[7]  = '{32'hFF9F_F4EF, 2'b11, 32'hFFFF_FFF8, "J_neg8"};
        vecs[8]  = '{32'hFFFF_FFFF, 2'b00, 32'hFFFF_FFFF, "I_ones"};
        vecs[9]  = '{32'hFFFF_FFFF, 2'b01, 32'hFFFF_FFFF, "S_ones"};
        vecs[10] = '{32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFE, "B_ones"};
        vecs[11] = '{32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE, "J_ones"};
        vecs[12] = '{32'h0000_0000, 2'b00, 32'h0000_0000, "I_zero"};
        vecs[13] = '{32'h0000_0000, 2'b01, 32'h0000_0000, "S_zero"};
        vecs[14] = '{32'h0000_0000, 2'b10, 32'h0000_0000, "B_zero"};
        vecs[15] = '{32'h0000_0000, 2'b11, 32'h0000_0000, "J_zero"};

        // Reset state: registered copy cleared, combinational follows inputs.
        rst_n   = 1'b0;
        instr   = 32'h0060_0093;
        control = 2'b00;
        #8;
        chk("reset_reg", ext_reg, 32'h0);
        chk("reset_comb", ext_comb, 32'h6);
        #4;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            instr   = vecs[i].instr;
            control = vecs[i].ctl;
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_comb"}, ext_comb, vecs[i].exp);
            chk({vecs[i].name, "_reg"}, ext_reg, vecs[i].exp);
        end

        // Mid-stream reset: J -8 loaded, then cleared without a clock edge.
        @(negedge clk);
        instr   = 32'hFF9F_F4EF;
        control = 2'b11;
        @(posedge clk);
        #1;
        chk("rst_seq_load", ext_reg, 32'hFFFF_FFF8);
        #2;
        instr   = 32'h0060_0093;
        control = 2'b00;
        rst_n   = 1'b0;
        #1;
        chk("rst_seq_async_clr", ext_reg, 32'h0);
        chk("rst_seq_comb", ext_comb, 32'h6);
        @(posedge clk);
        #1;
        chk("rst_seq_held", ext_reg, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_seq_released_no_edge", ext_reg, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_seq_first_load", ext_reg, 32'h6);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
